// File: rtl/minmax_scan_16bit_pkg.sv
// Shared types and sizing for the min/max scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package minmax_pkg;

    localparam int W       = 16;
    localparam int MAX_LEN = 16;
    localparam int CNT_W   = 5;
    localparam int IDX_W   = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACCEPT  = 3'd1,
        CMP_MAX = 3'd2,
        CMP_MIN = 3'd3,
        DONE    = 3'd4
    } state_t;

    // A scan length is usable when it is non-zero and fits the result storage.
    function automatic logic len_ok(input logic [CNT_W-1:0] l, input int max_len);
        return (l != '0) && (int'(l) <= max_len);
    endfunction

endpackage

// File: rtl/minmax_scan_16bit_if.sv
// Scan request, data stream and result bundle for the min/max scanner.
// Latency: n/a (wires only).
// Backpressure: in_ready gates in_data; start is only honoured while idle.
interface minmax_scan_16bit_if #(
    parameter int W     = minmax_pkg::W,
    parameter int CNT_W = minmax_pkg::CNT_W,
    parameter int IDX_W = minmax_pkg::IDX_W
);
    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic [W-1:0]     in_data;
    logic             in_ready;
    logic             busy;
    logic             done;
    logic             err;
    logic [W-1:0]     max_val;
    logic [W-1:0]     min_val;
    logic [IDX_W-1:0] max_idx;
    logic [IDX_W-1:0] min_idx;

    modport master (
        output start, len, in_valid, in_data,
        input  in_ready, busy, done, err, max_val, min_val, max_idx, min_idx
    );

    modport slave (
        input  start, len, in_valid, in_data,
        output in_ready, busy, done, err, max_val, min_val, max_idx, min_idx
    );
endinterface

// File: rtl/minmax_scan_16bit_ge.sv
// Unsigned greater-or-equal comparator shared by both compare phases.
// Latency: combinational.
// Backpressure: none.
module GE_16bit #(
    parameter int W = minmax_pkg::W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         ge
);
    assign ge = (a >= b);
endmodule

// File: rtl/minmax_scan_16bit.sv
// Scans len unsigned words and reports the largest/smallest value with earliest index.
// Latency: 1 cycle for the first word, 3 per further word, done one cycle after the last compare.
// Backpressure: in_ready only in ACCEPT; words are consumed on in_valid && in_ready.
module minmax_scan_16bit #(
    parameter int MAX_LEN = minmax_pkg::MAX_LEN,
    parameter int W       = minmax_pkg::W
) (
    input  logic              clk,
    input  logic              rst,
    minmax_scan_16bit_if.slave bus
);
    import minmax_pkg::*;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_inc;
    logic [CNT_W-1:0]  len_q;
    logic [W-1:0]      hold;
    logic [W-1:0]      max_val;
    logic [W-1:0]      min_val;
    logic [IDX_W-1:0]  max_idx;
    logic [IDX_W-1:0]  min_idx;

    logic              start_ok;
    logic              xfer;
    logic              first_word;
    logic              in_ready;
    logic              busy;
    logic              done;
    logic              err;
    logic [W-1:0]      ge_a;
    logic [W-1:0]      ge_b;
    logic              ge;

    assign start_ok   = len_ok(bus.len, MAX_LEN);
    assign xfer       = bus.in_valid && in_ready;
    assign first_word = (count == '0);
    assign count_inc  = count + 1'b1;

    // One comparator: CMP_MAX asks "is the current max still >= hold",
    // CMP_MIN asks "is hold >= the current min"; a 0 means replace.
    GE_16bit #(.W(W)) u_ge (
        .a  (ge_a),
        .b  (ge_b),
        .ge (ge)
    );

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        err       = 1'b0;
        ge_a      = max_val;
        ge_b      = hold;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (bus.start) begin
                    if (start_ok) begin
                        state_nxt = ACCEPT;
                    end else begin
                        err = 1'b1;
                    end
                end
            end
            ACCEPT: begin
                in_ready = 1'b1;
                if (xfer) begin
                    if (first_word) begin
                        state_nxt = (len_q == 5'd1) ? DONE : ACCEPT;
                    end else begin
                        state_nxt = CMP_MAX;
                    end
                end
            end
            CMP_MAX: begin
                ge_a      = max_val;
                ge_b      = hold;
                state_nxt = CMP_MIN;
            end
            CMP_MIN: begin
                ge_a      = hold;
                ge_b      = min_val;
                state_nxt = (count_inc == len_q) ? DONE : ACCEPT;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count   <= '0;
            len_q   <= '0;
            hold    <= '0;
            max_val <= '0;
            min_val <= '0;
            max_idx <= '0;
            min_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && start_ok) begin
                        len_q <= bus.len;
                        count <= '0;
                    end
                end
                ACCEPT: begin
                    if (xfer) begin
                        if (first_word) begin
                            max_val <= bus.in_data;
                            min_val <= bus.in_data;
                            max_idx <= '0;
                            min_idx <= '0;
                            count   <= 5'd1;
                        end else begin
                            hold <= bus.in_data;
                        end
                    end
                end
                CMP_MAX: begin
                    if (!ge) begin
                        max_val <= hold;
                        max_idx <= count[IDX_W-1:0];
                    end
                end
                CMP_MIN: begin
                    if (!ge) begin
                        min_val <= hold;
                        min_idx <= count[IDX_W-1:0];
                    end
                    count <= count_inc;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.err      = err;
    assign bus.max_val  = max_val;
    assign bus.min_val  = min_val;
    assign bus.max_idx  = max_idx;
    assign bus.min_idx  = min_idx;

endmodule

// File: tb/tb_minmax_scan_16bit.sv
// Randomized bench for the min/max scanner against a plain array-walk reference.
module tb_minmax_scan_16bit;

    logic clk = 1'b0;
    logic rst = 1'b1;

    minmax_scan_16bit_if bus ();

    minmax_scan_16bit #(.MAX_LEN(16), .W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [15:0] words [16];
    logic [15:0] exp_max;
    logic [15:0] exp_min;
    int          exp_max_idx;
    int          exp_min_idx;

    // Reference: first occurrence of the largest and smallest word.
    task automatic model(input int n);
        exp_max     = words[0];
        exp_min     = words[0];
        exp_max_idx = 0;
        exp_min_idx = 0;
        for (int i = 1; i < n; i++) begin
            if (words[i] > exp_max) begin
                exp_max     = words[i];
                exp_max_idx = i;
            end
            if (words[i] < exp_min) begin
                exp_min     = words[i];
                exp_min_idx = i;
            end
        end
    endtask

    task automatic run_scan(input int n, input int gap_pct, input bit hold_start, input string name);
        int idx;
        int first_cyc;
        int done_cyc;
        int ready_cnt;
        int extra;
        int busy_low;
        bit seen_done;
        bit xfer;
        idx = 0; first_cyc = -1; done_cyc = -1; ready_cnt = 0; extra = 0; busy_low = 0;
        seen_done = 1'b0;
        model(n);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.len   = 5'(n);
        @(posedge clk); #1;
        bus.start = hold_start;
        if (hold_start) bus.len = (n == 16) ? 5'd1 : 5'(n + 1);
        for (int c = 0; c < 400 && !seen_done; c++) begin
            bus.in_valid = (int'($urandom_range(0, 99)) >= gap_pct);
            bus.in_data  = (idx < n) ? words[idx] : 16'hDEAD;
            @(negedge clk);
            if (bus.done) begin
                seen_done = 1'b1;
                done_cyc  = cyc;
                bus.start = 1'b0;
            end
            if (!bus.busy) busy_low++;
            xfer = bus.in_valid && bus.in_ready;
            if (bus.in_ready) ready_cnt++;
            if (xfer) begin
                if (idx == 0) first_cyc = cyc;
                if (idx >= n) extra++;
                idx++;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;

        checks++;
        if (seen_done !== 1'b1) begin
            errors++;
            $display("FAIL %s done_timeout: done seen=%0d required=1", name, seen_done);
        end
        checks++;
        if (idx !== n || extra !== 0) begin
            errors++;
            $display("FAIL %s word_count: consumed=%0d required=%0d", name, idx, n);
        end
        checks++;
        if (busy_low !== 0) begin
            errors++;
            $display("FAIL %s busy_during_scan: idle cycles=%0d required=0", name, busy_low);
        end
        checks++;
        if (bus.max_val !== exp_max || bus.max_idx !== 4'(exp_max_idx)) begin
            errors++;
            $display("FAIL %s max: got %h@%0d required %h@%0d", name, bus.max_val, bus.max_idx, exp_max, exp_max_idx);
        end
        checks++;
        if (bus.min_val !== exp_min || bus.min_idx !== 4'(exp_min_idx)) begin
            errors++;
            $display("FAIL %s min: got %h@%0d required %h@%0d", name, bus.min_val, bus.min_idx, exp_min, exp_min_idx);
        end
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: done=%0b busy=%0b required 0 0", name, bus.done, bus.busy);
        end
        if (gap_pct == 0) begin
            checks++;
            if (done_cyc - first_cyc !== 3 * (n - 1) + 1) begin
                errors++;
                $display("FAIL %s latency: got %0d cycles required %0d", name, done_cyc - first_cyc, 3 * (n - 1) + 1);
            end
            checks++;
            if (ready_cnt !== n) begin
                errors++;
                $display("FAIL %s ready_cycles: got %0d required %0d", name, ready_cnt, n);
            end
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0 ||
            bus.max_val !== 16'h0 || bus.min_val !== 16'h0 || bus.max_idx !== 4'h0 || bus.min_idx !== 4'h0) begin
            errors++;
            $display("FAIL reset_state: rdy=%0b busy=%0b done=%0b err=%0b max=%h min=%h required all 0",
                     bus.in_ready, bus.busy, bus.done, bus.err, bus.max_val, bus.min_val);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_scenario1();
        words[0] = 16'd5; words[1] = 16'd9; words[2] = 16'd2; words[3] = 16'd9;
        run_scan(4, 0, 1'b0, "scen1");
        checks++;
        if (bus.max_val !== 16'd9 || bus.max_idx !== 4'd1 || bus.min_val !== 16'd2 || bus.min_idx !== 4'd2) begin
            errors++;
            $display("FAIL scen1_const: max %0d@%0d min %0d@%0d required 9@1 2@2",
                     bus.max_val, bus.max_idx, bus.min_val, bus.min_idx);
        end
    endtask

    task automatic test_single();
        words[0] = 16'hABCD;
        run_scan(1, 0, 1'b0, "single");
    endtask

    task automatic test_err();
        logic [4:0] bad [2];
        bad[0] = 5'd0;
        bad[1] = 5'd17;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            bus.start = 1'b1;
            bus.len   = bad[k];
            @(negedge clk);
            checks++;
            if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL err_pulse len=%0d: err=%0b busy=%0b required 1 0", bad[k], bus.err, bus.busy);
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            @(negedge clk);
            checks++;
            if (bus.err !== 1'b0 || bus.busy !== 1'b0 || bus.max_val !== exp_max || bus.min_val !== exp_min ||
                bus.max_idx !== 4'(exp_max_idx) || bus.min_idx !== 4'(exp_min_idx)) begin
                errors++;
                $display("FAIL err_after len=%0d: err=%0b busy=%0b max=%h min=%h required 0 0 %h %h",
                         bad[k], bus.err, bus.busy, bus.max_val, bus.min_val, exp_max, exp_min);
            end
        end
    endtask

    task automatic test_gaps();
        words[0]  = 16'hFFFF;
        words[1]  = 16'h0000;
        for (int i = 2; i < 15; i++) words[i] = 16'($urandom_range(1, 16'hFFFE));
        words[15] = 16'h8000;
        run_scan(16, 40, 1'b0, "gaps16");
    endtask

    task automatic test_reset_mid_scan();
        logic [15:0] w [3];
        for (int i = 0; i < 3; i++) w[i] = 16'($urandom_range(16'h0100, 16'hF000));
        @(posedge clk); #1;
        bus.start = 1'b1; bus.len = 5'd3;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.in_valid = 1'b1; bus.in_data = w[0];
        @(posedge clk); #1;
        bus.in_data = w[1];
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0 || bus.max_val !== w[0]) begin
            errors++;
            $display("FAIL pre_reset_cmp: busy=%0b rdy=%0b max=%h required 1 0 %h", bus.busy, bus.in_ready, bus.max_val, w[0]);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0 ||
            bus.max_val !== 16'h0 || bus.min_val !== 16'h0 || bus.max_idx !== 4'h0 || bus.min_idx !== 4'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs: busy=%0b max=%h min=%h required 0 0 0", bus.busy, bus.max_val, bus.min_val);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        begin
            int done_cnt;
            int busy_cnt;
            done_cnt = 0;
            busy_cnt = 0;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (bus.done) done_cnt++;
                if (bus.busy) busy_cnt++;
            end
            checks++;
            if (done_cnt !== 0 || busy_cnt !== 0) begin
                errors++;
                $display("FAIL post_reset_quiet: done=%0d busy=%0d cycles required 0 0", done_cnt, busy_cnt);
            end
        end
        for (int i = 0; i < 3; i++) words[i] = 16'($urandom);
        run_scan(3, 0, 1'b0, "after_reset");
    endtask

    task automatic test_start_held();
        for (int i = 0; i < 6; i++) words[i] = 16'($urandom_range(0, 7));
        run_scan(6, 0, 1'b1, "start_held");
    endtask

    task automatic test_random();
        for (int s = 0; s < 20; s++) begin
            int n;
            int narrow;
            n      = int'($urandom_range(1, 16));
            narrow = int'($urandom_range(0, 1));
            for (int i = 0; i < 16; i++)
                words[i] = narrow ? 16'($urandom_range(0, 3)) : 16'($urandom);
            run_scan(n, (s % 3 == 0) ? 0 : 30, 1'b0, "random");
        end
    endtask

    task automatic test_back_to_back();
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 5; i++) words[i] = 16'($urandom);
            run_scan(5, 0, 1'b0, "b2b");
        end
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.len      = 5'd0;
        bus.in_valid = 1'b0;
        bus.in_data  = 16'h0;
        test_reset();
        test_scenario1();
        test_single();
        test_err();
        test_gaps();
        test_reset_mid_scan();
        test_start_held();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
